// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - element-serial sequencer feeding one scalar ALU from vector registers
module vector_lane_sequencer #(
  parameter int LONGEST_LEN = 64,
  parameter int VLEN        = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             vl,
  input  logic [2:0]             vsew,
  input  logic [5:0]             opcode,
  input  logic                   vm,
  input  logic                   is_mask_operation,
  input  logic [1:0]             vec_operand_type,
  input  logic [63:0]            v0,
  input  logic [VLEN-1:0]        vs1_data,
  input  logic [VLEN-1:0]        vs2_data,
  input  logic [VLEN-1:0]        vs3_data,
  input  logic [LONGEST_LEN-1:0] rs,
  input  logic [LONGEST_LEN-1:0] imm,
  output logic [LONGEST_LEN-1:0] alu_vs1,
  output logic [LONGEST_LEN-1:0] alu_vs2,
  output logic [LONGEST_LEN-1:0] alu_vs3,
  output logic                   alu_mask,
  output logic                   alu_vm,
  output logic [5:0]             alu_opcode,
  output logic [2:0]             alu_vsew,
  output logic                   alu_is_mask,
  input  logic [LONGEST_LEN-1:0] alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VLEN-1:0]        vd_data,
  output logic                   out_error
);

  localparam logic [5:0] VECTOR_ADC = 6'd16;
  localparam logic [5:0] VECTOR_SBC = 6'd18;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [5:0]             idx;
  logic [9:0]             evl_r;
  logic [VLEN-1:0]        vd_buf;
  logic [VLEN-1:0]        vs1_r;
  logic [VLEN-1:0]        vs2_r;
  logic [VLEN-1:0]        vs3_r;
  logic [63:0]            v0_r;
  logic [LONGEST_LEN-1:0] rs_r;
  logic [LONGEST_LEN-1:0] imm_r;
  logic [5:0]             opcode_r;
  logic [2:0]             vsew_r;
  logic                   vm_r;
  logic                   mask_op_r;
  logic [1:0]             optype_r;

  logic                   accept;
  logic                   handshake;
  logic                   sew_legal;
  logic                   last_elem;
  logic                   elem_active;
  logic [9:0]             vlmax_in;
  logic [9:0]             evl_in;
  logic [9:0]             elem_shift;
  logic [LONGEST_LEN-1:0] sew_mask;
  logic [LONGEST_LEN-1:0] vs1_elem;
  logic [LONGEST_LEN-1:0] vs2_elem;
  logic [LONGEST_LEN-1:0] vs3_elem;
  logic [VLEN-1:0]        wr_mask;
  logic [VLEN-1:0]        wr_data;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign handshake = (state == DONE) && out_valid && out_ready;
  assign sew_legal = (vsew <= EIGHT_BYTE);
  assign vlmax_in  = 10'(VLEN >> (3 + vsew));
  assign evl_in    = ({2'b00, vl} < vlmax_in) ? {2'b00, vl} : vlmax_in;

  // Bit offset of the current element inside a vector register
  assign elem_shift = {4'b0000, idx} << (3 + vsew_r[1:0]);

  always_comb begin
    case (vsew_r[1:0])
      2'd0:    sew_mask = LONGEST_LEN'(8'hFF);
      2'd1:    sew_mask = LONGEST_LEN'(16'hFFFF);
      2'd2:    sew_mask = LONGEST_LEN'(32'hFFFF_FFFF);
      default: sew_mask = '1;
    endcase
  end

  assign vs1_elem    = LONGEST_LEN'(vs1_r >> elem_shift) & sew_mask;
  assign vs2_elem    = LONGEST_LEN'(vs2_r >> elem_shift) & sew_mask;
  assign vs3_elem    = LONGEST_LEN'(vs3_r >> elem_shift) & sew_mask;
  assign last_elem   = ({4'b0000, idx} == evl_r - 10'd1);
  // Carry/borrow ops consume v0 as an operand, so no element is masked off
  assign elem_active = vm_r || v0_r[idx] || (opcode_r == VECTOR_ADC) || (opcode_r == VECTOR_SBC);
  assign wr_mask     = VLEN'(sew_mask) << elem_shift;
  assign wr_data     = VLEN'(alu_result & sew_mask) << elem_shift;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (!sew_legal || evl_in == 10'd0) ? DONE : RUN;
      RUN:     if (last_elem) state_next = DONE;
      DONE:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_vs1     = '0;
    alu_vs2     = '0;
    alu_vs3     = '0;
    alu_mask    = 1'b0;
    alu_vm      = 1'b0;
    alu_opcode  = '0;
    alu_vsew    = '0;
    alu_is_mask = 1'b0;
    if (state == RUN) begin
      alu_vs2 = vs2_elem;
      alu_vs3 = vs3_elem;
      case (optype_r)
        2'd0:    alu_vs1 = vs1_elem;
        2'd1:    alu_vs1 = rs_r;
        2'd2:    alu_vs1 = imm_r;
        default: alu_vs1 = '0;
      endcase
      alu_mask    = v0_r[idx];
      alu_vm      = vm_r;
      alu_opcode  = opcode_r;
      alu_vsew    = vsew_r;
      alu_is_mask = mask_op_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      evl_r     <= '0;
      vd_buf    <= '0;
      vs1_r     <= '0;
      vs2_r     <= '0;
      vs3_r     <= '0;
      v0_r      <= '0;
      rs_r      <= '0;
      imm_r     <= '0;
      opcode_r  <= '0;
      vsew_r    <= '0;
      vm_r      <= 1'b0;
      mask_op_r <= 1'b0;
      optype_r  <= '0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
    end else begin
      // out_valid rises one cycle after DONE is entered and drops on the handshake edge
      out_valid <= (state == DONE) && !handshake;
      if (accept) begin
        idx       <= '0;
        evl_r     <= evl_in;
        vd_buf    <= vs3_data;
        vs1_r     <= vs1_data;
        vs2_r     <= vs2_data;
        vs3_r     <= vs3_data;
        v0_r      <= v0;
        rs_r      <= rs;
        imm_r     <= imm;
        opcode_r  <= opcode;
        vsew_r    <= vsew;
        vm_r      <= vm;
        mask_op_r <= is_mask_operation;
        optype_r  <= vec_operand_type;
        out_error <= !sew_legal;
      end else if (state == RUN) begin
        if (elem_active) begin
          if (mask_op_r) begin
            vd_buf[idx] <= alu_result[0];
          end else begin
            vd_buf <= (vd_buf & ~wr_mask) | wr_data;
          end
        end
        idx <= idx + 6'd1;
      end
    end
  end

  assign vd_data = vd_buf;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb/tb_vector_lane_sequencer.sv - directed and randomized checks of vector_lane_sequencer against a reference model
module tb_vector_lane_sequencer;

  localparam logic [5:0] VECTOR_ADD  = 6'd0;
  localparam logic [5:0] VECTOR_SUB  = 6'd2;
  localparam logic [5:0] VECTOR_MADD = 6'd4;
  localparam logic [5:0] VECTOR_ADC  = 6'd16;
  localparam logic [5:0] VECTOR_MADC = 6'd17;
  localparam logic [5:0] VECTOR_SBC  = 6'd18;

  typedef struct {
    logic [7:0]   vl;
    logic [2:0]   vsew;
    logic [5:0]   op;
    logic         vm;
    logic         is_mask;
    logic [1:0]   typ;
    logic [63:0]  v0;
    logic [63:0]  rs;
    logic [63:0]  imm;
    logic [511:0] vs1;
    logic [511:0] vs2;
    logic [511:0] vs3;
  } req_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   vl;
  logic [2:0]   vsew;
  logic [5:0]   opcode;
  logic         vm;
  logic         is_mask_operation;
  logic [1:0]   vec_operand_type;
  logic [63:0]  v0;
  logic [511:0] vs1_data;
  logic [511:0] vs2_data;
  logic [511:0] vs3_data;
  logic [63:0]  rs;
  logic [63:0]  imm;
  logic [63:0]  alu_vs1;
  logic [63:0]  alu_vs2;
  logic [63:0]  alu_vs3;
  logic         alu_mask;
  logic         alu_vm;
  logic [5:0]   alu_opcode;
  logic [2:0]   alu_vsew;
  logic         alu_is_mask;
  logic [63:0]  alu_result;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] vd_data;
  logic         out_error;

  int checks;
  int failures;

  vector_lane_sequencer #(.LONGEST_LEN(64), .VLEN(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .vl(vl), .vsew(vsew), .opcode(opcode), .vm(vm),
    .is_mask_operation(is_mask_operation), .vec_operand_type(vec_operand_type),
    .v0(v0), .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data),
    .rs(rs), .imm(imm),
    .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_vs3(alu_vs3),
    .alu_mask(alu_mask), .alu_vm(alu_vm), .alu_opcode(alu_opcode),
    .alu_vsew(alu_vsew), .alu_is_mask(alu_is_mask), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .vd_data(vd_data), .out_error(out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar ALU behaviour shared by the ALU stub and the reference model
  function automatic logic [63:0] alu_fn(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c3, input logic cin, input int sew, input logic mvm);
    logic [64:0] s;
    logic [63:0] m;
    m = (sew >= 64) ? {64{1'b1}} : ((64'd1 << sew) - 64'd1);
    case (op)
      VECTOR_ADD:  return a + b;
      VECTOR_SUB:  return a - b;
      VECTOR_MADD: return a * b + c3;
      VECTOR_ADC:  return a + b + 64'(cin);
      VECTOR_SBC:  return a - b - 64'(cin);
      VECTOR_MADC: begin
        s = {1'b0, a & m} + {1'b0, b & m} + 65'(cin & !mvm);
        return 64'(s[sew]);
      end
      default:     return 64'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_vs2, alu_vs1, alu_vs3, alu_mask, 8 << alu_vsew[1:0], alu_vm);

  function automatic req_t model_done(input req_t q);
    return q;
  endfunction

  function automatic logic [511:0] model_vd(input req_t q);
    logic [511:0] vd;
    logic [63:0]  m;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [63:0]  c3;
    logic [63:0]  r;
    int sew;
    int evl;
    vd = q.vs3;
    if (q.vsew > 3'd3) return vd;
    sew = 8 << q.vsew;
    evl = (int'(q.vl) < 512 / sew) ? int'(q.vl) : 512 / sew;
    m = (sew == 64) ? {64{1'b1}} : ((64'd1 << sew) - 64'd1);
    for (int i = 0; i < evl; i++) begin
      if (q.vm || q.v0[i] || q.op == VECTOR_ADC || q.op == VECTOR_SBC) begin
        a  = 64'(q.vs2 >> (i * sew)) & m;
        c3 = 64'(q.vs3 >> (i * sew)) & m;
        b  = (q.typ == 2'd0) ? (64'(q.vs1 >> (i * sew)) & m) : (q.typ == 2'd1) ? q.rs : q.imm;
        r  = alu_fn(q.op, a, b, c3, q.v0[i], sew, q.vm);
        if (q.is_mask) vd[i] = r[0];
        else for (int k = 0; k < sew; k++) vd[i * sew + k] = r[k];
      end
    end
    return vd;
  endfunction

  function automatic int model_lat(input req_t q);
    int sew;
    int evl;
    if (q.vsew > 3'd3) return 1;
    sew = 8 << q.vsew;
    evl = (int'(q.vl) < 512 / sew) ? int'(q.vl) : 512 / sew;
    return evl + 1;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i * 32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic req_t blank_req();
    req_t q;
    q.vl = '0; q.vsew = '0; q.op = '0; q.vm = 1'b0; q.is_mask = 1'b0; q.typ = '0;
    q.v0 = '0; q.rs = '0; q.imm = '0; q.vs1 = '0; q.vs2 = '0; q.vs3 = '0;
    return q;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    q.vl   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
    q.vsew = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0:       q.op = VECTOR_ADD;
      1:       q.op = VECTOR_SUB;
      2:       q.op = VECTOR_MADD;
      3:       q.op = VECTOR_ADC;
      4:       q.op = VECTOR_SBC;
      default: q.op = VECTOR_MADC;
    endcase
    q.is_mask = (q.op == VECTOR_MADC);
    q.vm  = 1'($urandom_range(0, 1));
    q.typ = 2'($urandom_range(0, 2));
    q.v0  = {$urandom(), $urandom()};
    q.rs  = {$urandom(), $urandom()};
    q.imm = {{59{1'b1}}, 5'($urandom_range(0, 31))};
    q.vs1 = rand512();
    q.vs2 = rand512();
    q.vs3 = rand512();
    return q;
  endfunction

  task automatic drive(input req_t q);
    vl = q.vl; vsew = q.vsew; opcode = q.op; vm = q.vm;
    is_mask_operation = q.is_mask; vec_operand_type = q.typ; v0 = q.v0;
    vs1_data = q.vs1; vs2_data = q.vs2; vs3_data = q.vs3; rs = q.rs; imm = q.imm;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input req_t q, input int hold, output logic [511:0] o_vd, output logic o_err, output int o_lat);
    logic [511:0] snap;
    @(negedge clk);
    chk("idle_in_ready", 512'(in_ready), 512'(1'b1));
    drive(q);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_lat = 0;
    for (int n = 1; n <= 300; n++) begin
      drive(rand_req());
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        o_lat = n;
        break;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    snap  = vd_data;
    o_err = out_error;
    chk("done_alu_zero", 512'({alu_vs1, alu_vs2, alu_vs3, alu_mask, alu_vm, alu_opcode, alu_vsew, alu_is_mask}), 512'(0));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_vd_stable", vd_data, snap);
      chk("hold_in_ready", 512'(in_ready), 512'(1'b0));
      chk("hold_out_valid", 512'(out_valid), 512'(1'b1));
    end
    out_ready = 1'b1;
    chk("leave_in_ready", 512'(in_ready), 512'(1'b0));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("after_out_valid", 512'(out_valid), 512'(1'b0));
    chk("after_in_ready", 512'(in_ready), 512'(1'b1));
    o_vd = snap;
  endtask

  req_t         q;
  logic [511:0] got_vd;
  logic         got_err;
  int           got_lat;
  logic         seen;
  logic [63:0]  exp_vs1;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(blank_req());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 512'(in_ready), 512'(1'b1));
    chk("reset_out_valid", 512'(out_valid), 512'(1'b0));
    chk("reset_out_error", 512'(out_error), 512'(1'b0));
    chk("reset_vd", vd_data, 512'(0));
    chk("reset_alu_zero", 512'({alu_vs1, alu_vs2, alu_vs3, alu_mask, alu_vm, alu_opcode, alu_vsew, alu_is_mask}), 512'(0));

    q = blank_req();
    q.vl = 8'd4; q.vsew = 3'd0; q.op = VECTOR_ADD; q.vm = 1'b1; q.typ = 2'd0;
    q.vs1 = {480'd0, 8'd4, 8'd3, 8'd2, 8'd1};
    q.vs2 = {480'd0, 8'd40, 8'd30, 8'd20, 8'd10};
    q.vs3 = {64{8'hFF}};
    run(q, 5, got_vd, got_err, got_lat);
    chk("vv_add_vd", got_vd, {{60{8'hFF}}, 8'd44, 8'd33, 8'd22, 8'd11});
    chk("vv_add_latency", 512'(got_lat), 512'(5));
    chk("vv_add_error", 512'(got_err), 512'(1'b0));

    q = blank_req();
    q.vl = 8'd3; q.vsew = 3'd2; q.op = VECTOR_SUB; q.vm = 1'b0; q.v0 = 64'b101; q.typ = 2'd0;
    q.vs1 = {16{32'd5}};
    q.vs2 = {16{32'd8}};
    q.vs3 = {16{32'h77}};
    run(q, 1, got_vd, got_err, got_lat);
    chk("masked_sub_vd", got_vd, {{13{32'h77}}, 32'd3, 32'h77, 32'd3});
    chk("masked_sub_latency", 512'(got_lat), 512'(4));

    q = blank_req();
    q.vl = 8'd2; q.vsew = 3'd3; q.op = VECTOR_MADC; q.vm = 1'b1; q.is_mask = 1'b1; q.typ = 2'd0;
    q.vs2 = {448'd0, 64'd0, {64{1'b1}}};
    q.vs1 = {448'd0, 64'd2, 64'd1};
    run(q, 0, got_vd, got_err, got_lat);
    chk("madc_vd", got_vd, 512'd1);

    q = rand_req();
    q.vl = 8'd0; q.vsew = 3'd1;
    run(q, 0, got_vd, got_err, got_lat);
    chk("vl0_vd", got_vd, q.vs3);
    chk("vl0_latency", 512'(got_lat), 512'(1));
    chk("vl0_error", 512'(got_err), 512'(1'b0));

    q = rand_req();
    q.vl = 8'd10; q.vsew = 3'b111;
    run(q, 2, got_vd, got_err, got_lat);
    chk("bad_sew_vd", got_vd, q.vs3);
    chk("bad_sew_error", 512'(got_err), 512'(1'b1));
    chk("bad_sew_latency", 512'(got_lat), 512'(1));

    q = rand_req();
    q.vl = 8'd200; q.vsew = 3'd3;
    run(q, 0, got_vd, got_err, got_lat);
    chk("vl200_vd", got_vd, model_vd(q));
    chk("vl200_latency", 512'(got_lat), 512'(9));

    q = rand_req();
    q.vl = 8'd8; q.vsew = 3'd0;
    @(negedge clk);
    drive(q);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    exp_vs1 = (q.typ == 2'd0) ? (64'(q.vs1 >> 16) & 64'hFF) : (q.typ == 2'd1) ? q.rs : q.imm;
    chk("midrun_vs2", 512'(alu_vs2), 512'(64'(q.vs2 >> 16) & 64'hFF));
    chk("midrun_vs1", 512'(alu_vs1), 512'(exp_vs1));
    chk("midrun_ctrl", 512'({alu_mask, alu_vm, alu_opcode, alu_vsew, alu_is_mask}),
        512'({q.v0[2], q.vm, q.op, q.vsew, q.is_mask}));
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 512'(out_valid), 512'(1'b0));
    chk("rst_vd", vd_data, 512'(0));
    chk("rst_alu_zero", 512'({alu_vs1, alu_vs2, alu_vs3, alu_mask, alu_vm, alu_opcode, alu_vsew, alu_is_mask}), 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_out_valid", 512'(seen), 512'(1'b0));
    chk("rst_in_ready", 512'(in_ready), 512'(1'b1));

    for (int t = 0; t < 24; t++) begin
      q = rand_req();
      run(q, $urandom_range(0, 3), got_vd, got_err, got_lat);
      chk("rand_vd", got_vd, model_vd(model_done(q)));
      chk("rand_latency", 512'(got_lat), 512'(model_lat(q)));
      chk("rand_error", 512'(got_err), 512'(q.vsew > 3'd3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
